// File: rtl/dram_arb_pkg.sv
// rtl/dram_arb_pkg.sv - shared types for the data-RAM port arbiter
package dram_arb_pkg;

    typedef enum logic {ARB, LOCKED} arb_state_t;

    typedef enum logic {OWN_CPU, OWN_LDR} owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - fixed-depth shift register carrying read ownership tags
module rd_tag_pipe
    import dram_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - round-robin arbiter sharing the data-RAM port between CPU and loader
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_lock,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_w_en,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_data
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    arb_state_t        state, state_nx;
    owner_t            rr_ptr, rr_ptr_nx;
    logic [CNT_W-1:0]  lock_cnt, lock_cnt_nx;
    logic              gnt_c, gnt_l;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, cpu_rdata_q, ldr_rdata_q;
    rd_tag_t           tag_in, tag_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB;
            rr_ptr      <= OWN_CPU;
            lock_cnt    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state       <= state_nx;
            rr_ptr      <= rr_ptr_nx;
            lock_cnt    <= lock_cnt_nx;
            addr_q      <= ram_addr;
            wdata_q     <= ram_in;
            cpu_rdata_q <= cpu_rdata;
            ldr_rdata_q <= ldr_rdata;
        end
    end

    always_comb begin
        state_nx    = state;
        rr_ptr_nx   = rr_ptr;
        lock_cnt_nx = lock_cnt;
        gnt_c       = 1'b0;
        gnt_l       = 1'b0;
        case (state)
            ARB: begin
                if (cpu_req && ldr_req) begin
                    gnt_c     = (rr_ptr == OWN_CPU);
                    gnt_l     = !gnt_c;
                    rr_ptr_nx = gnt_c ? OWN_LDR : OWN_CPU;
                end else begin
                    gnt_c = cpu_req;
                    gnt_l = ldr_req;
                end
                if (gnt_l && ldr_lock) begin
                    state_nx    = LOCKED;
                    lock_cnt_nx = CNT_W'(1);
                end
            end
            LOCKED: begin
                // Starvation break: one CPU slot without releasing the lock.
                if (lock_cnt == CNT_MAX && cpu_req) begin
                    gnt_c       = 1'b1;
                    lock_cnt_nx = '0;
                end else if (!ldr_req) begin
                    state_nx    = ARB;
                    rr_ptr_nx   = OWN_CPU;
                    lock_cnt_nx = '0;
                end else begin
                    gnt_l = 1'b1;
                    if (!cpu_req) begin
                        lock_cnt_nx = '0;
                    end else if (lock_cnt != CNT_MAX) begin
                        lock_cnt_nx = lock_cnt + 1'b1;
                    end
                    if (!ldr_lock) begin
                        state_nx    = ARB;
                        rr_ptr_nx   = OWN_CPU;
                        lock_cnt_nx = '0;
                    end
                end
            end
            default: begin
                state_nx = ARB;
            end
        endcase
    end

    // Grants are forced low while reset is asserted, even if requests are up.
    assign cpu_gnt  = rst_n && gnt_c;
    assign ldr_gnt  = rst_n && gnt_l;
    assign ram_addr = cpu_gnt ? cpu_addr  : (ldr_gnt ? ldr_addr  : addr_q);
    assign ram_in   = cpu_gnt ? cpu_wdata : (ldr_gnt ? ldr_wdata : wdata_q);
    assign ram_w_en = (cpu_gnt && cpu_we) || (ldr_gnt && ldr_we);

    always_comb begin
        tag_in       = '0;
        tag_in.valid = (cpu_gnt && !cpu_we) || (ldr_gnt && !ldr_we);
        tag_in.owner = ldr_gnt ? OWN_LDR : OWN_CPU;
    end

    rd_tag_pipe #(.DEPTH(RD_LAT)) u_rd_tag_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .tag_in (tag_in),
        .tag_out(tag_out)
    );

    assign cpu_rvalid = tag_out.valid && (tag_out.owner == OWN_CPU);
    assign ldr_rvalid = tag_out.valid && (tag_out.owner == OWN_LDR);
    assign cpu_rdata  = cpu_rvalid ? ram_data : cpu_rdata_q;
    assign ldr_rdata  = ldr_rvalid ? ram_data : ldr_rdata_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - randomized and directed checks of dram_port_arbiter against a reference model
module tb_dram_port_arbiter;

    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 32;
    localparam int RD_LAT   = 1;
    localparam int LOCK_MAX = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_gnt, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              ldr_req = 1'b0, ldr_lock = 1'b0, ldr_we = 1'b0;
    logic [ADDR_W-1:0] ldr_addr = '0;
    logic [DATA_W-1:0] ldr_wdata = '0;
    logic              ldr_gnt, ldr_rvalid;
    logic [DATA_W-1:0] ldr_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_w_en;
    logic [DATA_W-1:0] ram_in;
    logic [DATA_W-1:0] ram_data = '0;

    int total = 0;
    int bad = 0;

    dram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_lock(ldr_lock), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .ram_addr(ram_addr), .ram_w_en(ram_w_en), .ram_in(ram_in), .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    // RAM behind the port, and the model's own copy of what memory should hold
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] mm  [2**ADDR_W];

    always @(posedge clk) begin
        if (ram_w_en) mem[ram_addr] <= ram_in;
        ram_data <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    bit                m_locked, m_tie_ldr;
    int                m_cnt;
    bit                pv [RD_LAT];
    bit                po [RD_LAT];
    logic [DATA_W-1:0] pd [RD_LAT];
    bit                e_cg, e_lg, e_we, e_crv, e_lrv;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_in, e_crd, e_lrd;
    bit                g_we, g_own, g_any;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_locked = 0; m_tie_ldr = 0; m_cnt = 0;
            for (int i = 0; i < RD_LAT; i++) pv[i] = 0;
            e_cg = 0; e_lg = 0; e_we = 0; e_crv = 0; e_lrv = 0;
            e_addr = '0; e_in = '0; e_crd = '0; e_lrd = '0;
        end else begin
            e_crv = pv[RD_LAT-1] && !po[RD_LAT-1];
            e_lrv = pv[RD_LAT-1] && po[RD_LAT-1];
            if (e_crv) e_crd = pd[RD_LAT-1];
            if (e_lrv) e_lrd = pd[RD_LAT-1];
            e_cg = 0; e_lg = 0;
            if (!m_locked) begin
                if (cpu_req && ldr_req) begin
                    if (m_tie_ldr) e_lg = 1; else e_cg = 1;
                    m_tie_ldr = e_cg;
                end else begin
                    e_cg = cpu_req; e_lg = ldr_req;
                end
                if (e_lg && ldr_lock) begin m_locked = 1; m_cnt = 1; end
            end else if (m_cnt == LOCK_MAX && cpu_req) begin
                e_cg = 1; m_cnt = 0;
            end else if (!ldr_req) begin
                m_locked = 0; m_tie_ldr = 0;
            end else begin
                e_lg = 1;
                m_cnt = cpu_req ? ((m_cnt < LOCK_MAX) ? m_cnt + 1 : LOCK_MAX) : 0;
                if (!ldr_lock) begin m_locked = 0; m_tie_ldr = 0; end
            end
            g_any = e_cg || e_lg;
            g_own = e_lg;
            g_we   = e_cg ? cpu_we    : ldr_we;
            g_addr = e_cg ? cpu_addr  : ldr_addr;
            g_data = e_cg ? cpu_wdata : ldr_wdata;
            e_we = g_any && g_we;
            if (g_any) begin
                e_addr = g_addr; e_in = g_data;
                if (g_we) mm[g_addr] = g_data;
            end
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pv[i] = pv[i-1]; po[i] = po[i-1]; pd[i] = pd[i-1];
            end
            pv[0] = g_any && !g_we;
            po[0] = g_own;
            pd[0] = mm[g_addr];
        end
        chk("cpu_gnt",    32'(cpu_gnt),    32'(e_cg));
        chk("ldr_gnt",    32'(ldr_gnt),    32'(e_lg));
        chk("ram_w_en",   32'(ram_w_en),   32'(e_we));
        chk("ram_addr",   32'(ram_addr),   32'(e_addr));
        chk("ram_in",     ram_in,          e_in);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
        chk("ldr_rvalid", 32'(ldr_rvalid), 32'(e_lrv));
        chk("cpu_rdata",  cpu_rdata,       e_crd);
        chk("ldr_rdata",  ldr_rdata,       e_lrd);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; ldr_req = 0; ldr_we = 0; ldr_lock = 0;
    endtask

    logic [3:0]  gs;
    logic [19:0] cg;
    int          lg_cnt;
    bit          c_pend, l_pend;

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) begin
            mem[i] = 32'h1000_0000 + i;
            mm[i]  = 32'h1000_0000 + i;
        end
        mem[16] = 32'hDEADBEEF;
        mm[16]  = 32'hDEADBEEF;

        // reset with a pending CPU request: no grant may leak out
        cpu_req = 1;
        look();
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        cpu_req = 0;
        step(); step();
        rst_n = 1;

        // CPU-only read
        step(); cpu_req = 1; cpu_we = 0; cpu_addr = 11'h010;
        look(); chk("t1_gnt", 32'(cpu_gnt), 32'd1);
        step(); idle();
        look(); chk("t1_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("t1_ldr_rvalid", 32'(ldr_rvalid), 32'd0);

        // contention, round-robin alternation
        gs = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            cpu_req = 1; cpu_we = 0; cpu_addr = 11'h001;
            ldr_req = 1; ldr_we = 0; ldr_addr = 11'h002; ldr_lock = 0;
            look(); gs = {gs[2:0], cpu_gnt};
        end
        step(); idle();
        look(); chk("t2_order", 32'(gs), 32'b1010);
        chk("t2_ldr_rvalid", 32'(ldr_rvalid), 32'd1);
        chk("t2_ldr_rdata", ldr_rdata, 32'h1000_0002);

        // loader write to top address
        step(); ldr_req = 1; ldr_we = 1; ldr_addr = 11'h7FF; ldr_wdata = 32'h12345678;
        look(); chk("t3_w_en", 32'(ram_w_en), 32'd1);
        chk("t3_addr", 32'(ram_addr), 32'h7FF);
        chk("t3_in", ram_in, 32'h12345678);
        step(); idle();
        look(); chk("t3_w_en_off", 32'(ram_w_en), 32'd0);
        chk("t3_no_rvalid", 32'(ldr_rvalid), 32'd0);
        chk("t3_addr_hold", 32'(ram_addr), 32'h7FF);

        // locked burst with a waiting CPU
        cg = '0; lg_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            ldr_req = 1; ldr_lock = 1; ldr_we = 1;
            ldr_addr = 11'(32'h20 + lg_cnt); ldr_wdata = 32'hA000_0000 + lg_cnt;
            cpu_req = (i > 0); cpu_we = 0; cpu_addr = 11'h003;
            look();
            cg[i] = cpu_gnt;
            if (ldr_gnt) lg_cnt++;
        end
        chk("t4_pattern", 32'(cg), 32'h20100);
        chk("t4_ldr_grants", lg_cnt, 32'd18);

        // lock release by dropping the loader request for one cycle
        step(); idle();
        look(); chk("t5_no_gnt", 32'(ldr_gnt), 32'd0);
        step();
        cpu_req = 1; cpu_we = 0; cpu_addr = 11'h004;
        ldr_req = 1; ldr_we = 0; ldr_addr = 11'h005;
        look(); chk("t5_cpu_first", 32'(cpu_gnt), 32'd1);
        step(); idle();

        // reset while a read is in flight
        step(); cpu_req = 1; cpu_we = 0; cpu_addr = 11'h005;
        look(); chk("t6_gnt", 32'(cpu_gnt), 32'd1);
        step(); idle(); rst_n = 0;
        look(); chk("t6_no_rvalid", 32'(cpu_rvalid), 32'd0);
        step(); rst_n = 1;
        look(); chk("t6_rdata0", cpu_rdata, 32'd0);
        chk("t6_addr0", 32'(ram_addr), 32'd0);
        step();
        cpu_req = 1; cpu_addr = 11'h006; ldr_req = 1; ldr_addr = 11'h007;
        look(); chk("t6_cpu_first", 32'(cpu_gnt), 32'd1);
        step(); idle();

        // randomized traffic, each requester holding its request until granted
        c_pend = 0; l_pend = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (c_pend && e_cg) c_pend = 0;
            if (l_pend && e_lg) l_pend = 0;
            if (!c_pend && $urandom_range(0, 2) != 0) begin
                c_pend = 1;
                cpu_we = 1'($urandom);
                cpu_addr = 11'($urandom_range(0, 15));
                cpu_wdata = $urandom;
            end
            if (!l_pend && $urandom_range(0, 3) != 0) begin
                l_pend = 1;
                ldr_we = 1'($urandom);
                ldr_lock = ($urandom_range(0, 7) != 0);
                ldr_addr = ($urandom_range(0, 9) == 0) ? 11'h7FF : 11'($urandom_range(0, 15));
                ldr_wdata = $urandom;
            end
            cpu_req = c_pend;
            ldr_req = l_pend;
        end
        step(); idle();
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
